// File: rtl/apb_reg_slave.sv
// APB completer: small word-aligned register window with programmable wait states and a
// read-only completed-transfer counter. Define APB_SLV_ERR_EN to report misses/counter writes on pslverr_o.
`timescale 1ns/1ps
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int          NUM_REGS    = 4,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wcnt;
  logic [31:0]       addr_lat;
  logic [31:0]       data_lat;
  logic              write_lat;
  logic [31:0]       regs [NUM_REGS];
  logic [31:0]       xfer_cnt;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              hit;
  logic              setup;
  logic              ready;
  logic              commit;
  logic [31:0]       rdata;

  assign setup  = psel_i && !penable_i;
  assign offset = addr_lat - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  // Addresses below the base wrap to a huge offset and fall out of the window.
  assign hit    = (offset[1:0] == 2'b00) && (offset < 32'(4 * NUM_REGS));
  assign ready  = (state == S_ACCESS) && (wcnt == 4'd0) && psel_i && penable_i;
  assign commit = ready && write_lat && hit && (idx != CNT_IDX);

  assign pready_o = ready;
  assign prdata_o = rdata;

  always_ff @(posedge pclk) begin
    if (preset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (setup) state_nxt = S_ACCESS;
      S_ACCESS: if (!psel_i || ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // A SETUP in either state (re)starts the transfer and reloads the wait counter.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wcnt <= 4'd0;
    end else if (setup) begin
      wcnt <= 4'(WAIT_CYCLES);
    end else if ((state == S_ACCESS) && psel_i && penable_i && (wcnt != 4'd0)) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (setup) begin
      addr_lat  <= paddr_i;
      write_lat <= pwrite_i;
      data_lat  <= pwdata_i;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      xfer_cnt <= '0;
    end else begin
      if (ready)  xfer_cnt  <= xfer_cnt + 32'd1;
      if (commit) regs[idx] <= data_lat;
    end
  end

  // Counter reads see the value before this transfer's own increment.
  always_comb begin
    rdata = '0;
    if (ready && !write_lat && hit) begin
      if (idx == CNT_IDX) rdata = xfer_cnt;
      else                rdata = regs[idx];
    end
  end

`ifdef APB_SLV_ERR_EN
  assign pslverr_o = ready && (!hit || (write_lat && (idx == CNT_IDX)));
`else
  assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: three instances (1, 0 and 3 wait states) on separate buses.
`timescale 1ns/1ps
module tb_apb_reg_slave;

  localparam int W0 = 1;
  localparam int W1 = 0;
  localparam int W2 = 3;
`ifdef APB_SLV_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        preset;
  logic        psel [3];
  logic        penable [3];
  logic        pwrite [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [31:0] paddr [3];
  logic [31:0] pwdata [3];
  logic [31:0] prdata [3];

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq [$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(4), .WAIT_CYCLES(W0)) dut0 (
    .pclk(clk), .preset(preset), .psel_i(psel[0]), .penable_i(penable[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]));

  apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(4), .WAIT_CYCLES(W1)) dut1 (
    .pclk(clk), .preset(preset), .psel_i(psel[1]), .penable_i(penable[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]));

  apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(4), .WAIT_CYCLES(W2)) dut2 (
    .pclk(clk), .preset(preset), .psel_i(psel[2]), .penable_i(penable[2]),
    .paddr_i(paddr[2]), .pwrite_i(pwrite[2]), .pwdata_i(pwdata[2]),
    .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]));

  function automatic int wait_of(input int k);
    return (k == 0) ? W0 : (k == 1) ? W1 : W2;
  endfunction

  // Monitor: pops one expectation per pready pulse; outside pready, outputs must read 0.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (pready[k] === 1'b1) begin
          if (sbq.size() == 0 || sbq[0].k != k) begin
            n_fail++;
            $display("FAIL unexpected_pready dut%0d cycle %0d: got pready=1, required 0", k, cyc);
          end else begin
            e = sbq.pop_front();
            if (cyc != e.cyc || prdata[k] !== e.data || pslverr[k] !== e.err) begin
              n_fail++;
              $display("FAIL xfer dut%0d: got cycle %0d prdata %h pslverr %b, required cycle %0d prdata %h pslverr %b",
                       k, cyc, prdata[k], pslverr[k], e.cyc, e.data, e.err);
            end
          end
        end else if (pready[k] !== 1'b0 || prdata[k] !== 32'h0 || pslverr[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs dut%0d cycle %0d: got pready %b prdata %h pslverr %b, required 0/0/0",
                   k, cyc, pready[k], prdata[k], pslverr[k]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // One complete transfer; the expected response is queued at SETUP time.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; paddr[k] = a; pwrite[k] = w; pwdata[k] = wd;
    e.k = k; e.cyc = cyc + 1 + wait_of(k); e.data = w ? 32'h0 : ed; e.err = ee;
    sbq.push_back(e);
    @(posedge clk); #1;
    penable[k] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pready[k] === 1'b1) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout dut%0d addr %h: got no pready, required pready within 40 cycles", k, a);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0;
    end
    repeat (n) @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = 32'h0; pwdata[k] = 32'h0;
    end
    preset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_pready%0d", k), {31'h0, pready[k]}, 32'h0);
      check($sformatf("reset_prdata%0d", k), prdata[k], 32'h0);
      check($sformatf("reset_pslverr%0d", k), {31'h0, pslverr[k]}, 32'h0);
    end
    @(posedge clk); #1;
    preset = 1'b0;
    mon_en = 1'b1;

    // One wait state: write, read back, counter shows two completed transfers.
    xfer(0, 32'hA000, 1'b1, 32'h0000_0005, 32'h0, 1'b0);
    xfer(0, 32'hA000, 1'b0, 32'h0, 32'h0000_0005, 1'b0);
    xfer(0, 32'hA00C, 1'b0, 32'h0, 32'h0000_0002, 1'b0);
    idle(2);

    // Zero wait states.
    xfer(1, 32'hA004, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer(1, 32'hA004, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(1, 32'hA008, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(2);

    // Misses, misaligned, below-base and counter write; all still count.
    xfer(0, 32'hA010, 1'b0, 32'h0, 32'h0, ERR_EN);
    xfer(0, 32'hA00C, 1'b1, 32'h0000_1234, 32'h0, ERR_EN);
    xfer(0, 32'hA002, 1'b0, 32'h0, 32'h0, ERR_EN);
    xfer(0, 32'h9FFC, 1'b0, 32'h0, 32'h0, ERR_EN);
    xfer(0, 32'hA00C, 1'b0, 32'h0, 32'h0000_0007, 1'b0);
    xfer(0, 32'hA000, 1'b0, 32'h0, 32'h0000_0005, 1'b0);
    idle(2);

    // Three wait states, then an aborted write of 0x77 (psel drops at T2).
    xfer(2, 32'hA000, 1'b1, 32'h0000_0011, 32'h0, 1'b0);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'hA000; pwrite[2] = 1'b1; pwdata[2] = 32'h77;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (6) @(posedge clk);
    xfer(2, 32'hA000, 1'b0, 32'h0, 32'h0000_0011, 1'b0);
    xfer(2, 32'hA00C, 1'b0, 32'h0, 32'h0000_0002, 1'b0);
    idle(2);

    // Counter wrap on the zero-wait instance.
    @(negedge clk);
    force dut1.xfer_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.xfer_cnt;
    xfer(1, 32'hA00C, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    xfer(1, 32'hA00C, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    idle(2);

    // Reset at T1 of a write of 0xAA to 0xA004.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'hA004; pwrite[0] = 1'b1; pwdata[0] = 32'hAA;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_pready", {31'h0, pready[0]}, 32'h0);
    check("rst_mid_prdata", prdata[0], 32'h0);
    check("rst_mid_pslverr", {31'h0, pslverr[0]}, 32'h0);
    idle(1);
    xfer(0, 32'hA004, 1'b0, 32'h0, 32'h0, 1'b0);
    xfer(0, 32'hA00C, 1'b0, 32'h0, 32'h0000_0001, 1'b0);
    xfer(1, 32'hA00C, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);

    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
